// File: rtl/fadd_vector_runner.sv
// fadd_vector_runner
//   Runs a table of float_adder test vectors in hardware. It reads operand A,
//   operand B and the expected sum from three memories that share one address.
//   It drives the operands into the external combinational adder and compares
//   the returned sum with the expected word bit for bit. It counts passes and
//   fails and records the index of the first failing vector.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   start, num_vec   launch a run of num_vec vectors (0..2**ADDR_W), ignored while busy
//   mem_addr, mem_rd shared read address and a one-cycle read strobe per vector
//   a_data, b_data, exp_data   memory read data, valid MEM_LAT cycles after mem_rd
//   op_a, op_b       registered operands to float_adder
//   sum              float_adder result (combinational from op_a/op_b)
//   busy, done       run in progress / run complete (done held until next start)
//   mismatch         one-cycle pulse in the compare cycle of a failing vector
//   pass_cnt, fail_cnt, first_fail_vld, first_fail_idx   run results
//
// state | meaning
// IDLE  | no run since reset; waiting for start
// ISSUE | mem_rd high for the current index
// WAIT  | waiting MEM_LAT cycles for memory data; operands captured on the last one
// CHECK | compare sum against the expected word, update results, advance
// DONE  | run complete; results held; start launches a new run
module fadd_vector_runner #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_vec,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    input  logic [DATA_W-1:0] exp_data,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] sum,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [ADDR_W:0]   pass_cnt,
    output logic [ADDR_W:0]   fail_cnt,
    output logic              first_fail_vld,
    output logic [ADDR_W-1:0] first_fail_idx
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int LAT_W = $clog2(MEM_LAT + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);
    localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(MEM_LAT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last_idx;
    logic [LAT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] exp_r;
    logic              sum_bad;

    // idx doubles as the memory address: it only changes on the way into
    // ISSUE, so the address holds its last value everywhere else.
    assign mem_addr = idx;
    assign mem_rd   = (state == S_ISSUE);
    assign busy     = (state == S_ISSUE) || (state == S_WAIT) || (state == S_CHECK);
    assign done     = (state == S_DONE);
    // Plain bit compare: +0/-0 and differing NaN payloads are failures.
    assign sum_bad  = (sum != exp_r);
    assign mismatch = (state == S_CHECK) && sum_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            idx            <= '0;
            last_idx       <= '0;
            wait_cnt       <= '0;
            exp_r          <= '0;
            op_a           <= '0;
            op_b           <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        // num_vec is at most 2**ADDR_W, so num_vec-1 always fits in idx.
                        last_idx       <= ADDR_W'(num_vec - CNT_ONE);
                        pass_cnt       <= '0;
                        fail_cnt       <= '0;
                        first_fail_vld <= 1'b0;
                        first_fail_idx <= '0;
                        if (num_vec == '0) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= '0;
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= LAT_LOAD;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == LAT_ONE) begin
                        op_a  <= a_data;
                        op_b  <= b_data;
                        exp_r <= exp_data;
                        state <= S_CHECK;
                    end else begin
                        wait_cnt <= wait_cnt - LAT_ONE;
                    end
                end
                S_CHECK: begin
                    if (sum_bad) begin
                        fail_cnt <= fail_cnt + CNT_ONE;
                        if (!first_fail_vld) begin
                            first_fail_vld <= 1'b1;
                            first_fail_idx <= idx;
                        end
                    end else begin
                        pass_cnt <= pass_cnt + CNT_ONE;
                    end
                    if (idx == last_idx) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + IDX_ONE;
                        state <= S_ISSUE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fadd_vector_runner.sv
module tb_fadd_vector_runner;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance 1: MEM_LAT=1
    logic        start1;
    logic [5:0]  num_vec1;
    logic [4:0]  mem_addr1;
    logic        mem_rd1;
    logic [31:0] a_data1, b_data1, exp_data1;
    logic [31:0] op_a1, op_b1, sum1;
    logic        busy1, done1, mismatch1, ffv1;
    logic [5:0]  pass1, fail1;
    logic [4:0]  ffi1;

    // Instance 3: MEM_LAT=3
    logic        start3;
    logic [5:0]  num_vec3;
    logic [4:0]  mem_addr3;
    logic        mem_rd3;
    logic [31:0] op_a3, op_b3, sum3;
    logic        busy3, done3, mismatch3, ffv3;
    logic [5:0]  pass3, fail3;
    logic [4:0]  ffi3;
    logic [31:0] s_a[3], s_b[3], s_e[3];

    fadd_vector_runner #(.ADDR_W(5), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .num_vec(num_vec1),
        .mem_addr(mem_addr1), .mem_rd(mem_rd1),
        .a_data(a_data1), .b_data(b_data1), .exp_data(exp_data1),
        .op_a(op_a1), .op_b(op_b1), .sum(sum1),
        .busy(busy1), .done(done1), .mismatch(mismatch1),
        .pass_cnt(pass1), .fail_cnt(fail1),
        .first_fail_vld(ffv1), .first_fail_idx(ffi1)
    );

    fadd_vector_runner #(.ADDR_W(5), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .num_vec(num_vec3),
        .mem_addr(mem_addr3), .mem_rd(mem_rd3),
        .a_data(s_a[2]), .b_data(s_b[2]), .exp_data(s_e[2]),
        .op_a(op_a3), .op_b(op_b3), .sum(sum3),
        .busy(busy3), .done(done3), .mismatch(mismatch3),
        .pass_cnt(pass3), .fail_cnt(fail3),
        .first_fail_vld(ffv3), .first_fail_idx(ffi3)
    );

    // Vector tables shared by both instances
    logic [31:0] mem_a[32], mem_b[32], mem_e[32];

    // Hand-computed IEEE-754 single-precision sums
    logic [31:0] pa[5] = '{32'h3f800000, 32'h3f800000, 32'h40000000, 32'h3f000000, 32'h3f800000};
    logic [31:0] pb[5] = '{32'h3f800000, 32'h40000000, 32'h40000000, 32'h3f000000, 32'hbf800000};
    logic [31:0] ps[5] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h3f800000, 32'h00000000};

    // Stand-in for float_adder, covering exactly the operand pairs used here
    function automatic logic [31:0] fadd_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3f800000, 32'h3f800000}: return 32'h40000000; // 1+1
            {32'h3f800000, 32'h40000000}: return 32'h40400000; // 1+2
            {32'h40000000, 32'h40000000}: return 32'h40800000; // 2+2
            {32'h3f000000, 32'h3f000000}: return 32'h3f800000; // .5+.5
            {32'h3f800000, 32'hbf800000}: return 32'h00000000; // 1-1 = +0
            default:                      return 32'h7fc00000;
        endcase
    endfunction

    assign sum1 = fadd_model(op_a1, op_b1);
    assign sum3 = fadd_model(op_a3, op_b3);

    // Memory models: latency 1 for instance 1, three-stage pipeline for instance 3
    always @(posedge clk) begin
        if (mem_rd1) begin
            a_data1   <= mem_a[mem_addr1];
            b_data1   <= mem_b[mem_addr1];
            exp_data1 <= mem_e[mem_addr1];
        end
        if (mem_rd3) begin
            s_a[0] <= mem_a[mem_addr3];
            s_b[0] <= mem_b[mem_addr3];
            s_e[0] <= mem_e[mem_addr3];
        end
        s_a[1] <= s_a[0]; s_a[2] <= s_a[1];
        s_b[1] <= s_b[0]; s_b[2] <= s_b[1];
        s_e[1] <= s_e[0]; s_e[2] <= s_e[1];
    end

    // Event monitors
    int cyc = 0, rd1_cnt = 0, mm1_cnt = 0, rd3_cnt = 0;
    int rd3_t[8];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd1)   rd1_cnt <= rd1_cnt + 1;
        if (mismatch1) mm1_cnt <= mm1_cnt + 1;
        if (mem_rd3) begin
            if (rd3_cnt < 8) rd3_t[rd3_cnt] <= cyc;
            rd3_cnt <= rd3_cnt + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run1(input int nv);
        num_vec1 = 6'(nv);
        start1   = 1'b1;
        tick();
        start1   = 1'b0;
    endtask

    task automatic wait_done1(input int max, output int n);
        n = 0;
        while (done1 !== 1'b1 && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic fill_table();
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = pa[i % 5];
            mem_b[i] = pb[i % 5];
            mem_e[i] = ps[i % 5];
        end
        mem_e[5]  = mem_e[5] ^ 32'h1;
        mem_e[17] = mem_e[17] ^ 32'h1;
    endtask

    int n, rd0, mm0;

    initial begin
        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; num_vec1 = '0; num_vec3 = '0;
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = '0; mem_b[i] = '0; mem_e[i] = '0;
        end
        tick(); tick();
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_mem_rd", mem_rd1, 0);
        check("rst_mem_addr", mem_addr1, 0);
        check("rst_op_a", op_a1, 0);
        check("rst_counts", {pass1, fail1, ffv1, ffi1}, 0);
        rst = 1'b0;
        tick();

        // 1: single passing vector, done 4 cycles after start
        mem_a[0] = 32'h3f800000; mem_b[0] = 32'h3f800000; mem_e[0] = 32'h40000000;
        mm0 = mm1_cnt;
        start_run1(1);
        check("t1_busy", busy1, 1);
        wait_done1(50, n);
        check("t1_latency", n + 1, 4);
        check("t1_pass", pass1, 1);
        check("t1_fail", fail1, 0);
        check("t1_ffv", ffv1, 0);
        check("t1_mismatch_pulses", mm1_cnt - mm0, 0);
        check("t1_op_a", op_a1, 32'h3f800000);

        // 2: expected word off by one ULP
        mem_e[0] = 32'h40000001;
        mm0 = mm1_cnt;
        start_run1(1);
        wait_done1(50, n);
        check("t2_latency", n + 1, 4);
        check("t2_pass", pass1, 0);
        check("t2_fail", fail1, 1);
        check("t2_mismatch_pulses", mm1_cnt - mm0, 1);
        check("t2_ffv", ffv1, 1);
        check("t2_ffi", ffi1, 0);

        // 2b: +0 result against -0 expected is a mismatch
        mem_b[0] = 32'hbf800000; mem_e[0] = 32'h80000000;
        start_run1(1);
        wait_done1(50, n);
        check("t2b_fail", {pass1, fail1}, {6'd0, 6'd1});

        // 3: 32 vectors, wrong at 5 and 17
        fill_table();
        rd0 = rd1_cnt; mm0 = mm1_cnt;
        start_run1(32);
        check("t3_mem_rd_first", mem_rd1, 1);
        wait_done1(400, n);
        check("t3_run_len", n, 96);
        check("t3_pass", pass1, 30);
        check("t3_fail", fail1, 2);
        check("t3_ffi", {ffv1, ffi1}, {1'b1, 5'd5});
        check("t3_rd_pulses", rd1_cnt - rd0, 32);
        check("t3_mismatch_pulses", mm1_cnt - mm0, 2);
        check("t3_last_addr", mem_addr1, 31);

        // 4: num_vec=0 restart from DONE
        rd0 = rd1_cnt;
        start_run1(0);
        check("t4_done", done1, 1);
        check("t4_counts", {pass1, fail1, ffv1}, 0);
        tick(); tick();
        check("t4_no_rd", rd1_cnt - rd0, 0);
        check("t4_busy", busy1, 0);

        // 5a: start pulsed mid-run is ignored
        rd0 = rd1_cnt;
        start_run1(32);
        repeat (7) tick();
        num_vec1 = 6'd3; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        wait_done1(400, n);
        check("t5_run_len", n + 8, 96);
        check("t5_counts", {pass1, fail1}, {6'd30, 6'd2});
        check("t5_rd_pulses", rd1_cnt - rd0, 32);

        // 5b: reset during CHECK of idx 10
        start_run1(32);
        repeat (32) tick();
        check("t5_pre_addr", mem_addr1, 10);
        check("t5_pre_counts", {pass1, fail1}, {6'd9, 6'd1});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_busy_done", {busy1, done1, mem_rd1}, 0);
        check("t5_rst_counts", {pass1, fail1, ffv1, ffi1}, 0);
        check("t5_rst_regs", {op_a1, mem_addr1}, 0);
        rd0 = rd1_cnt;
        repeat (4) tick();
        check("t5_idle", {busy1, done1, 32'(rd1_cnt - rd0)}, 0);

        // 6: MEM_LAT=3, four vectors
        num_vec3 = 6'd4; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        n = 0;
        while (done3 !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("t6_run_len", n, 20);
        check("t6_pass", {pass3, fail3}, {6'd4, 6'd0});
        check("t6_rd_pulses", rd3_cnt, 4);
        check("t6_gap1", rd3_t[1] - rd3_t[0], 5);
        check("t6_gap3", rd3_t[3] - rd3_t[2], 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
